rect_draw_arbiter: RTL and testbench

- Shares the single pixel-write port of the VGA adapter (x, y, colour, plot) between N_REQ rectangle-drawing requesters, e.g. screen clear, player sprite and punch effect.
- Each requester submits a filled rectangle (origin, size, colour).
- The block grants requesters round-robin and scans the granted rectangle one pixel per clock, row-major.
- Off-screen pixels are clipped.
- The block sits directly between the drawing controllers and the vga_adapter instance.

---
 rtl/vga_draw_pkg.sv | 27 ++
 rtl/rr_arbiter.sv | 31 +++
 rtl/rect_draw_arbiter.sv | 141 ++++++++++++++
 tb/tb_rect_draw_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_draw_pkg.sv
// Shared screen geometry, pixel-port widths and FSM encodings for the
// rectangle draw path feeding the VGA adapter.
package vga_draw_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int COL_W    = 3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DRAW = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef struct packed {
        logic [X_W-1:0]   x;
        logic [Y_W-1:0]   y;
        logic [X_W-1:0]   w;
        logic [Y_W-1:0]   h;
        logic [COL_W-1:0] colour;
    } rect_t;

    function automatic logic rect_empty(input rect_t r);
        return (r.w == '0) || (r.h == '0);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after rr_ptr,
// wrapping cyclically.
module rr_arbiter #(
    parameter int N_REQ = 3,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        cand  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = IDX_W'((int'(rr_ptr) + k) % N_REQ);
            if (!valid && req[cand]) begin
                valid       = 1'b1;
                idx         = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rect_draw_arbiter.sv
// Round-robin arbiter sharing the VGA adapter pixel port between rectangle
// drawers; scans the granted rectangle row-major, one pixel per clock.
//
//   state   | meaning
//   IDLE    | waiting for a request; latches the picked rectangle
//   DRAW    | emitting one (possibly clipped) pixel per cycle
//   DONE    | one-cycle done pulse, advance rr_ptr, release grant
module rect_draw_arbiter
    import vga_draw_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int X_MAX = SCREEN_W,
    parameter int Y_MAX = SCREEN_H
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*X_W-1:0]   req_x,
    input  logic [N_REQ*Y_W-1:0]   req_y,
    input  logic [N_REQ*X_W-1:0]   req_w,
    input  logic [N_REQ*Y_W-1:0]   req_h,
    input  logic [N_REQ*COL_W-1:0] req_colour,
    output logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       done,
    output logic                   busy,
    output logic [X_W-1:0]         x_out,
    output logic [Y_W-1:0]         y_out,
    output logic [COL_W-1:0]       colour_out,
    output logic                   plot
);

    localparam int IDX_W = (N_REQ > 2) ? 2 : 1;
    localparam logic [X_W:0] X_LIM = (X_W + 1)'(X_MAX);
    localparam logic [Y_W:0] Y_LIM = (Y_W + 1)'(Y_MAX);

    logic [1:0]       state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] gnt_idx;
    logic [X_W-1:0]   cx;
    logic [Y_W-1:0]   cy;
    rect_t            rect;

    rect_t            req_rect [N_REQ];
    logic [N_REQ-1:0] pick_oh;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_valid;
    rect_t            pick_rect;

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign req_rect[g].x      = req_x[g*X_W +: X_W];
        assign req_rect[g].y      = req_y[g*Y_W +: Y_W];
        assign req_rect[g].w      = req_w[g*X_W +: X_W];
        assign req_rect[g].h      = req_h[g*Y_W +: Y_W];
        assign req_rect[g].colour = req_colour[g*COL_W +: COL_W];
    end

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req    (req),
        .rr_ptr (rr_ptr),
        .grant  (pick_oh),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

    assign pick_rect = req_rect[pick_idx];

    // Full-width sums so that coordinates wrapping the port width clip, not plot.
    logic [X_W:0] x_sum;
    logic [Y_W:0] y_sum;
    logic         clipped;
    logic         last_col;
    logic         last_row;

    assign x_sum    = {1'b0, rect.x} + {1'b0, cx};
    assign y_sum    = {1'b0, rect.y} + {1'b0, cy};
    assign clipped  = (x_sum >= X_LIM) || (y_sum >= Y_LIM);
    assign last_col = (cx == rect.w - X_W'(1));
    assign last_row = (cy == rect.h - Y_W'(1));

    assign busy = (state != ST_IDLE);
    assign done = grant & {N_REQ{state == ST_DONE}};

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            rr_ptr     <= '0;
            gnt_idx    <= '0;
            grant      <= '0;
            cx         <= '0;
            cy         <= '0;
            rect       <= '0;
            plot       <= 1'b0;
            x_out      <= '0;
            y_out      <= '0;
            colour_out <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    plot <= 1'b0;
                    if (pick_valid) begin
                        rect    <= pick_rect;
                        gnt_idx <= pick_idx;
                        grant   <= pick_oh;
                        cx      <= '0;
                        cy      <= '0;
                        state   <= rect_empty(pick_rect) ? ST_DONE : ST_DRAW;
                    end
                end
                ST_DRAW: begin
                    x_out      <= x_sum[X_W-1:0];
                    y_out      <= y_sum[Y_W-1:0];
                    colour_out <= rect.colour;
                    plot       <= !clipped;
                    if (last_col) begin
                        cx <= '0;
                        cy <= cy + Y_W'(1);
                        if (last_row)
                            state <= ST_DONE;
                    end else begin
                        cx <= cx + X_W'(1);
                    end
                end
                ST_DONE: begin
                    plot   <= 1'b0;
                    grant  <= '0;
                    rr_ptr <= (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
                    state  <= ST_IDLE;
                end
                default: begin
                    plot  <= 1'b0;
                    grant <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rect_draw_arbiter.sv
// Scoreboard bench for rect_draw_arbiter: stimulus pushes expected pixels and
// done pulses with their cycle stamps; a monitor pops them as the DUT emits.
module tb_rect_draw_arbiter;

    localparam int N = 3;

    logic           clk = 1'b0;
    logic           resetn;
    logic [N-1:0]   req;
    logic [N*8-1:0] req_x;
    logic [N*7-1:0] req_y;
    logic [N*8-1:0] req_w;
    logic [N*7-1:0] req_h;
    logic [N*3-1:0] req_colour;
    logic [N-1:0]   grant;
    logic [N-1:0]   done;
    logic           busy;
    logic [7:0]     x_out;
    logic [6:0]     y_out;
    logic [2:0]     colour_out;
    logic           plot;

    rect_draw_arbiter #(.N_REQ(N), .X_MAX(160), .Y_MAX(120)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .req        (req),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_w      (req_w),
        .req_h      (req_h),
        .req_colour (req_colour),
        .grant      (grant),
        .done       (done),
        .busy       (busy),
        .x_out      (x_out),
        .y_out      (y_out),
        .colour_out (colour_out),
        .plot       (plot)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int x;
        int y;
        int c;
    } pix_t;

    typedef struct {
        int cyc;
        int idx;
    } done_t;

    pix_t  pix_q[$];
    done_t done_q[$];
    int    checks = 0;
    int    errors = 0;
    bit    mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic push_pix(input int c, input int x, input int y, input int col);
        pix_t p;
        p.cyc = c; p.x = x; p.y = y; p.c = col;
        pix_q.push_back(p);
    endtask

    task automatic push_done(input int c, input int idx);
        done_t d;
        d.cyc = c; d.idx = idx;
        done_q.push_back(d);
    endtask

    task automatic set_rect(input int i, input int x, input int y, input int w,
                            input int h, input int col);
        req_x[i*8 +: 8]      = 8'(x);
        req_y[i*7 +: 7]      = 7'(y);
        req_w[i*8 +: 8]      = 8'(w);
        req_h[i*7 +: 7]      = 7'(h);
        req_colour[i*3 +: 3] = 3'(col);
    endtask

    task automatic monitor();
        pix_t  p;
        done_t d;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (plot) begin
                    checks++;
                    if (pix_q.size() == 0) begin
                        errors++;
                        $display("FAIL pixel_unexpected @cyc %0d: got (%0d,%0d,c%0d) expected no plot",
                                 cyc, x_out, y_out, colour_out);
                    end else begin
                        p = pix_q.pop_front();
                        if (p.cyc != cyc || int'(x_out) != p.x || int'(y_out) != p.y ||
                            int'(colour_out) != p.c) begin
                            errors++;
                            $display("FAIL pixel: got (%0d,%0d,c%0d)@%0d expected (%0d,%0d,c%0d)@%0d",
                                     x_out, y_out, colour_out, cyc, p.x, p.y, p.c, p.cyc);
                        end
                    end
                end
                if (done != '0) begin
                    checks++;
                    if (done_q.size() == 0) begin
                        errors++;
                        $display("FAIL done_unexpected @cyc %0d: got done=%b expected none", cyc, done);
                    end else begin
                        d = done_q.pop_front();
                        if (d.cyc != cyc || done != N'(1 << d.idx) || grant != done) begin
                            errors++;
                            $display("FAIL done: got done=%b grant=%b @%0d expected done[%0d] @%0d",
                                     done, grant, cyc, d.idx, d.cyc);
                        end
                    end
                end
                chk("grant_onehot0", 32'($onehot0(grant)), 32'd1);
            end
        end
    endtask

    int t;

    initial begin
        resetn = 1'b0;
        req = '0; req_x = '0; req_y = '0; req_w = '0; req_h = '0; req_colour = '0;

        fork
            monitor();
            begin
                repeat (20000) @(posedge clk);
                errors++;
                $display("FAIL watchdog: got no completion expected finish within 20000 cycles");
                $display("Simulation finished: %0d checks, %0d errors", checks, errors);
                $finish;
            end
        join_none

        repeat (3) @(negedge clk);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_plot", 32'(plot), 32'd0);
        chk("rst_xyc", {x_out, y_out, colour_out}, 32'd0);
        resetn = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);

        // 2x2 box on requester 1
        t = cyc;
        set_rect(1, 10, 20, 2, 2, 5);
        req[1] = 1'b1;
        push_pix(t+2, 10, 20, 5); push_pix(t+3, 11, 20, 5);
        push_pix(t+4, 10, 21, 5); push_pix(t+5, 11, 21, 5);
        push_done(t+5, 1);
        @(negedge clk);
        chk("box_grant", 32'(grant), 32'b010);
        chk("box_busy", 32'(busy), 32'd1);
        repeat (4) @(negedge clk);
        req[1] = 1'b0;
        @(negedge clk);
        chk("box_busy_low", 32'(busy), 32'd0);
        chk("box_grant_low", 32'(grant), 32'd0);

        // empty rectangle on requester 0 (rr_ptr=2 wraps to 0)
        t = cyc;
        set_rect(0, 30, 30, 0, 5, 1);
        req[0] = 1'b1;
        push_done(t+1, 0);
        @(negedge clk);
        req[0] = 1'b0;
        @(negedge clk);

        // clipping at the bottom-right corner on requester 2
        t = cyc;
        set_rect(2, 158, 118, 4, 3, 2);
        req[2] = 1'b1;
        push_pix(t+2, 158, 118, 2); push_pix(t+3, 159, 118, 2);
        push_pix(t+6, 158, 119, 2); push_pix(t+7, 159, 119, 2);
        push_done(t+13, 2);
        repeat (12) @(negedge clk);
        chk("clip_busy_mid", 32'(busy), 32'd1);
        @(negedge clk);
        req[2] = 1'b0;
        @(negedge clk);

        // contention, rr_ptr=0: grants 0,1,2,0 three cycles apart
        t = cyc;
        set_rect(0, 1, 5, 1, 1, 1);
        set_rect(1, 11, 6, 1, 1, 2);
        set_rect(2, 21, 7, 1, 1, 3);
        req = 3'b111;
        for (int j = 0; j < 4; j++) begin
            push_pix(t+2+3*j, (j%3)*10 + 1, (j%3) + 5, (j%3) + 1);
            push_done(t+2+3*j, j%3);
        end
        repeat (11) @(negedge clk);
        req = '0;
        @(negedge clk);

        // reset during an 8x8 draw, rr_ptr=1
        t = cyc;
        set_rect(1, 0, 0, 8, 8, 6);
        req[1] = 1'b1;
        for (int k = 0; k < 10; k++) push_pix(t+2+k, k%8, k/8, 6);
        repeat (11) @(negedge clk);
        resetn = 1'b0;
        req = '0;
        @(negedge clk);
        chk("mrst_plot", 32'(plot), 32'd0);
        chk("mrst_grant", 32'(grant), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_x", 32'(x_out), 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        // fresh request after reset: rr_ptr=0 must pick 0 before 2
        t = cyc;
        set_rect(0, 5, 6, 1, 1, 1);
        set_rect(2, 7, 8, 1, 1, 2);
        req = 3'b101;
        push_pix(t+2, 5, 6, 1); push_done(t+2, 0);
        push_pix(t+5, 7, 8, 2); push_done(t+5, 2);
        @(negedge clk);
        chk("post_rst_grant", 32'(grant), 32'b001);
        @(negedge clk);
        req[0] = 1'b0;
        repeat (3) @(negedge clk);
        req[2] = 1'b0;
        @(negedge clk);

        // requester 2 drops req right after grant; rectangle still completes
        t = cyc;
        set_rect(2, 50, 60, 3, 1, 7);
        req[2] = 1'b1;
        push_pix(t+2, 50, 60, 7); push_pix(t+3, 51, 60, 7); push_pix(t+4, 52, 60, 7);
        push_done(t+4, 2);
        @(negedge clk);
        chk("drop_grant", 32'(grant), 32'b100);
        req[2] = 1'b0;
        repeat (5) @(negedge clk);
        chk("drop_no_regrant", 32'(grant), 32'd0);
        chk("drop_idle", 32'(busy), 32'd0);

        repeat (3) @(negedge clk);
        chk("pix_q_drained", 32'(pix_q.size()), 32'd0);
        chk("done_q_drained", 32'(done_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
